// File: rtl/debug_link_ctrl.sv
`default_nettype none
// ============================================================================
// debug_link_ctrl : UART-side program loader, RUN/DEBUG sequencer and state dump
// Revision 1.0
// ============================================================================
module debug_link_ctrl #(
  parameter int DATA_W     = 32,
  parameter int PM_DEPTH   = 64,
  parameter int DUMP_WORDS = 128,
  parameter int MAX_CYCLES = 65535,
  localparam int BYTES     = DATA_W / 8,
  localparam int PM_AW     = (PM_DEPTH > 1) ? $clog2(PM_DEPTH) : 1,
  localparam int DA_W      = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_RX_EMPTY,
  input  logic [7:0]        I_RX_DATA,
  output logic              O_RD_UART,
  input  logic              I_TX_FULL,
  output logic              O_WR_UART,
  output logic [7:0]        O_DATA_UART,
  output logic              O_PM_WE,
  output logic [PM_AW-1:0]  O_PM_ADDR,
  output logic [DATA_W-1:0] O_PM_DATA,
  output logic              O_CPU_EN,
  output logic              O_CPU_RESET,
  input  logic              I_HALT,
  output logic [DA_W-1:0]   O_DUMP_ADDR,
  input  logic [DATA_W-1:0] I_DUMP_DATA
);

  localparam int NW_W = $clog2(PM_DEPTH + 1);
  localparam int BC_W = $clog2(BYTES + 1);

  typedef enum logic [2:0] {
    WAIT_N        = 3'd0,
    RECEIVE_INSTR = 3'd1,
    LOAD_PM       = 3'd2,
    WAIT_OP       = 3'd3,
    RUN           = 3'd4,
    SEND_RUN      = 3'd5,
    DEBUG         = 3'd6,
    SEND_DEBUG    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SP_START = 2'd0,
    SP_SHIFT = 2'd1,
    SP_CAP   = 2'd2,
    SP_DRAIN = 2'd3
  } send_t;

  state_t              state;
  send_t               snd;
  logic [NW_W-1:0]     n_words;
  logic [NW_W-1:0]     pm_idx;
  logic [BC_W-1:0]     rx_cnt;
  logic [BC_W-1:0]     byte_left;
  logic [DATA_W-1:0]   asm_word;
  logic [DATA_W-1:0]   shreg;
  logic [DA_W:0]       word_idx;
  logic [31:0]         cyc_cnt;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                pm_we;
  logic [PM_AW-1:0]    pm_addr;
  logic [DATA_W-1:0]   pm_data;
  logic                cpu_reset;
  logic                step_en;
  logic [DA_W-1:0]     dump_addr;

  logic                accept_state;
  logic                take;
  logic                run_exit;
  logic                run_en;
  logic                push;
  logic                slot_free;
  logic                last_word;
  logic [DATA_W-1:0]   asm_next;
  logic [NW_W-1:0]     idx_next;
  logic [31:0]         cnt_inc;

  assign accept_state = (state == WAIT_N) || (state == RECEIVE_INSTR) ||
                        (state == WAIT_OP) || (state == DEBUG);
  assign take      = !RESET && accept_state && !I_RX_EMPTY;
  assign run_exit  = I_HALT || (cyc_cnt == 32'(MAX_CYCLES));
  // The first RUN cycle is the core reset cycle; halt is not trusted until after it.
  assign run_en    = (state == RUN) && !cpu_reset && !run_exit;
  assign push      = tx_valid && !I_TX_FULL;
  assign slot_free = !tx_valid || !I_TX_FULL;
  assign last_word = (word_idx == (DA_W + 1)'(DUMP_WORDS));
  assign asm_next  = (asm_word << 8) | DATA_W'(I_RX_DATA);
  assign idx_next  = pm_idx + NW_W'(1);
  assign cnt_inc   = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

  assign O_RD_UART   = take;
  assign O_WR_UART   = push;
  assign O_DATA_UART = tx_data;
  assign O_PM_WE     = pm_we;
  assign O_PM_ADDR   = pm_addr;
  assign O_PM_DATA   = pm_data;
  assign O_CPU_EN    = run_en || step_en;
  assign O_CPU_RESET = cpu_reset;
  assign O_DUMP_ADDR = dump_addr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= WAIT_N;
      snd       <= SP_START;
      n_words   <= '0;
      pm_idx    <= '0;
      rx_cnt    <= '0;
      byte_left <= '0;
      asm_word  <= '0;
      shreg     <= '0;
      word_idx  <= '0;
      cyc_cnt   <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      pm_we     <= 1'b0;
      pm_addr   <= '0;
      pm_data   <= '0;
      cpu_reset <= 1'b0;
      step_en   <= 1'b0;
      dump_addr <= '0;
    end else begin
      pm_we     <= 1'b0;
      cpu_reset <= 1'b0;
      step_en   <= 1'b0;
      if (push) tx_valid <= 1'b0;

      unique case (state)
        WAIT_N: begin
          if (take && (I_RX_DATA != 8'd0)) begin
            n_words <= (32'(I_RX_DATA) > 32'(PM_DEPTH)) ? NW_W'(PM_DEPTH)
                                                          : NW_W'(I_RX_DATA);
            pm_idx  <= '0;
            rx_cnt  <= '0;
            state   <= RECEIVE_INSTR;
          end
        end

        RECEIVE_INSTR: begin
          if (take) begin
            asm_word <= asm_next;
            if (rx_cnt == BC_W'(BYTES - 1)) begin
              rx_cnt  <= '0;
              pm_we   <= 1'b1;
              pm_addr <= pm_idx[PM_AW-1:0];
              pm_data <= asm_next;
              state   <= LOAD_PM;
            end else begin
              rx_cnt <= rx_cnt + BC_W'(1);
            end
          end
        end

        LOAD_PM: begin
          pm_idx <= idx_next;
          state  <= (idx_next < n_words) ? RECEIVE_INSTR : WAIT_OP;
        end

        WAIT_OP: begin
          if (take) begin
            case (I_RX_DATA)
              8'h52: begin
                state     <= RUN;
                cpu_reset <= 1'b1;
                cyc_cnt   <= '0;
              end
              8'h44: begin
                state     <= DEBUG;
                cpu_reset <= 1'b1;
                cyc_cnt   <= '0;
              end
              8'h4C:   state <= WAIT_N;
              default: ;
            endcase
          end
        end

        RUN: begin
          if (!cpu_reset) begin
            if (run_exit) begin
              state <= SEND_RUN;
              snd   <= SP_START;
            end else begin
              cyc_cnt <= cnt_inc;
            end
          end
        end

        DEBUG: begin
          if (take) begin
            case (I_RX_DATA)
              8'h53: begin
                step_en <= 1'b1;
                cyc_cnt <= cnt_inc;
                state   <= SEND_DEBUG;
                snd     <= SP_START;
              end
              8'h45:   state <= WAIT_OP;
              default: ;
            endcase
          end
        end

        SEND_RUN, SEND_DEBUG: begin
          unique case (snd)
            SP_START: begin
              shreg     <= DATA_W'(cyc_cnt);
              byte_left <= BC_W'(BYTES);
              word_idx  <= '0;
              snd       <= SP_SHIFT;
            end
            SP_SHIFT: begin
              if (slot_free) begin
                tx_data   <= shreg[DATA_W-1 -: 8];
                tx_valid  <= 1'b1;
                shreg     <= shreg << 8;
                byte_left <= byte_left - BC_W'(1);
                // Issue the next dump address alongside the last byte so the
                // capture costs a single dead cycle per word.
                if (byte_left == BC_W'(1)) begin
                  if (last_word) begin
                    snd <= SP_DRAIN;
                  end else begin
                    dump_addr <= word_idx[DA_W-1:0];
                    snd       <= SP_CAP;
                  end
                end
              end
            end
            SP_CAP: begin
              shreg     <= I_DUMP_DATA;
              word_idx  <= word_idx + (DA_W + 1)'(1);
              byte_left <= BC_W'(BYTES);
              snd       <= SP_SHIFT;
            end
            SP_DRAIN: begin
              if (slot_free) begin
                snd   <= SP_START;
                state <= ((state == SEND_DEBUG) && !I_HALT) ? DEBUG : WAIT_OP;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_link_ctrl.sv
`default_nettype none
// ============================================================================
// tb_debug_link_ctrl : scoreboard bench for the debug link controller
// Revision 1.0
// ============================================================================
module tb_debug_link_ctrl;

  localparam int DATA_W     = 32;
  localparam int PM_DEPTH   = 64;
  localparam int DUMP_WORDS = 8;
  localparam int MAX_CYCLES = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rd_uart;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  data_uart;
  logic        pm_we;
  logic [5:0]  pm_addr;
  logic [31:0] pm_data;
  logic        cpu_en;
  logic        cpu_reset;
  logic        halt;
  logic [2:0]  dump_addr;
  logic [31:0] dump_data;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } pm_t;

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  pm_t        exp_pm[$];

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int rst_cnt = 0;
  int tx_seen = 0;

  always #5 clk = ~clk;

  // Combinational dump source: every word is a known function of its address.
  assign dump_data = {8'hD0, 5'd0, dump_addr, 8'hA5, 8'h3C ^ {5'd0, dump_addr}};

  debug_link_ctrl #(
    .DATA_W(DATA_W), .PM_DEPTH(PM_DEPTH), .DUMP_WORDS(DUMP_WORDS), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .CLK(clk), .RESET(rst), .I_RX_EMPTY(rx_empty), .I_RX_DATA(rx_data), .O_RD_UART(rd_uart),
    .I_TX_FULL(tx_full), .O_WR_UART(wr_uart), .O_DATA_UART(data_uart),
    .O_PM_WE(pm_we), .O_PM_ADDR(pm_addr), .O_PM_DATA(pm_data),
    .O_CPU_EN(cpu_en), .O_CPU_RESET(cpu_reset), .I_HALT(halt),
    .O_DUMP_ADDR(dump_addr), .I_DUMP_DATA(dump_data)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic push_frame(input logic [31:0] cnt);
    for (int b = 3; b >= 0; b--) exp_tx.push_back(cnt[b*8 +: 8]);
    for (int k = 0; k < DUMP_WORDS; k++) begin
      exp_tx.push_back(8'hD0);
      exp_tx.push_back(8'(k));
      exp_tx.push_back(8'hA5);
      exp_tx.push_back(8'h3C ^ 8'(k));
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int left;
    left = budget;
    while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_pm.size() != 0) && left > 0) begin
      @(posedge clk); #1;
      left--;
    end
    check({name, "_drained"}, 64'(left > 0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // RX FIFO model: show-ahead head byte, popped on a consumed cycle.
  initial begin
    logic took;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      took = rd_uart;
      @(posedge clk); #1;
      if (took && rx_q.size() != 0) void'(rx_q.pop_front());
      rx_empty = (rx_q.size() == 0);
      rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a PM write or a TX push.
  initial begin
    pm_t e;
    forever begin
      @(negedge clk);
      if (pm_we) begin
        if (exp_pm.size() == 0) check("pm_unexpected", 64'(pm_addr), 64'hFFFF);
        else begin
          e = exp_pm.pop_front();
          check("pm_addr", 64'(pm_addr), 64'(e.addr));
          check("pm_data", 64'(pm_data), 64'(e.data));
        end
      end
      if (wr_uart) begin
        tx_seen++;
        if (tx_full) check("push_while_full", 64'(wr_uart), 64'd0);
        if (exp_tx.size() == 0) check("tx_unexpected", 64'(data_uart), 64'hFFFF);
        else check("tx_byte", 64'(data_uart), 64'(exp_tx.pop_front()));
      end
      if (cpu_en) en_cnt++;
      if (cpu_reset) rst_cnt++;
    end
  end

  initial begin
    int base_en, base_rst, base_tx, p0, left;
    rst = 1'b1; tx_full = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({rd_uart, wr_uart, data_uart, pm_we, pm_addr, cpu_en, cpu_reset, dump_addr}), 64'd0);
    check("reset_pm_data", 64'(pm_data), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word load, then a stray byte that WAIT_OP must swallow.
    foreach (rx_q[i]) ;
    rx_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h99};
    exp_pm.push_back('{addr: 6'd0, data: 32'h11223344});
    exp_pm.push_back('{addr: 6'd1, data: 32'hAABBCCDD});
    wait_drain("load2", 200);

    // RUN with halt raised after ten enabled cycles.
    base_en = en_cnt; base_rst = rst_cnt;
    push_frame(32'd10);
    rx_q.push_back(8'h52);
    left = 200;
    while (en_cnt - base_en < 10 && left > 0) begin
      @(posedge clk); #1;
      left--;
    end
    check("run_halt_en_seen", 64'(left > 0), 64'd1);
    halt = 1'b1;
    wait_drain("run_halt", 400);
    halt = 1'b0;
    check("run_halt_en_cycles", 64'(en_cnt - base_en), 64'd10);
    check("run_halt_cpu_reset", 64'(rst_cnt - base_rst), 64'd1);

    // RUN to the watchdog, with the TX FIFO stalled mid-frame.
    base_en = en_cnt; base_tx = tx_seen;
    push_frame(32'd100);
    rx_q.push_back(8'h52);
    left = 400;
    while (tx_seen - base_tx < 6 && left > 0) begin
      @(posedge clk); #1;
      left--;
    end
    check("wd_frame_started", 64'(left > 0), 64'd1);
    tx_full = 1'b1;
    p0 = tx_seen;
    repeat (20) @(posedge clk);
    #1;
    check("full_no_push", 64'(tx_seen - p0), 64'd0);
    tx_full = 1'b0;
    wait_drain("watchdog", 400);
    check("wd_en_cycles", 64'(en_cnt - base_en), 64'd100);

    // DEBUG: two single steps then exit.
    base_en = en_cnt; base_rst = rst_cnt;
    push_frame(32'd1);
    push_frame(32'd2);
    rx_q = '{8'h44, 8'h53, 8'h53, 8'h45};
    wait_drain("debug", 600);
    check("debug_en_pulses", 64'(en_cnt - base_en), 64'd2);
    check("debug_cpu_reset", 64'(rst_cnt - base_rst), 64'd1);

    // Reload from WAIT_OP: N=0 ignored, N=0x50 clamped to 64 words.
    rx_q = '{8'h4C, 8'h00, 8'h50};
    for (int w = 0; w < PM_DEPTH; w++) begin
      rx_q.push_back(8'(w));
      rx_q.push_back(8'h5A);
      rx_q.push_back(8'(255 - w));
      rx_q.push_back(8'h11);
      exp_pm.push_back('{addr: 6'(w), data: {8'(w), 8'h5A, 8'(255 - w), 8'h11}});
    end
    wait_drain("clamp", 1500);

    // Reset during a frame aborts it; the link restarts in WAIT_N.
    base_tx = tx_seen;
    push_frame(32'd100);
    rx_q.push_back(8'h52);
    left = 400;
    while (tx_seen - base_tx < 5 && left > 0) begin
      @(posedge clk); #1;
      left--;
    end
    check("rst_frame_started", 64'(left > 0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs",
          64'({rd_uart, wr_uart, data_uart, pm_we, pm_addr, cpu_en, cpu_reset, dump_addr}), 64'd0);
    check("midframe_reset_pm_data", 64'(pm_data), 64'd0);
    exp_tx.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rx_q = '{8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    exp_pm.push_back('{addr: 6'd0, data: 32'hCAFEF00D});
    wait_drain("post_reset_load", 200);

    check("leftover_tx", 64'(exp_tx.size()), 64'd0);
    check("leftover_pm", 64'(exp_pm.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
